// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - latency-programmable memory responder with tristate read data
module mem_bus_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_req,
    input  logic        mem_rd_wr,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_wr_size,
    inout  wire  [31:0] mem_data,
    output logic        mem_data_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND,
        S_TURN
    } state_t;

    localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

    state_t                  state, state_n;
    logic [7:0]              cnt, cnt_n;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [31:0]             data_q;
    logic                    accept;
    logic                    drive;
    logic [7:0]              lat_load;
    logic [2:0]              nbytes;
    logic [3:0]              wr_be;
    logic [31:0]             wr_word;
    logic [31:0]             rdata;
    logic                    commit;

    logic [31:0]             store [2**ADDR_WIDTH];

    // Address bits above the store are aliased away on purpose.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

    assign lat_load = mem_rd_wr ? WR_LOAD : RD_LOAD;
    assign rdata    = store[addr_q[ADDR_WIDTH+1:2]];
    assign mem_data = drive ? rdata : 'z;
    assign commit   = (state == S_RESPOND) && wr_q;
    assign nbytes   = (size_q == 2'b00) ? 3'd4 : {1'b0, size_q};

    // State, latency counter and request capture; capture is frozen after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            size_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= mem_addr[ADDR_WIDTH+1:0];
                wr_q   <= mem_rd_wr;
                size_q <= mem_wr_size;
                data_q <= mem_data;
            end
        end
    end

    // Next-state, counter, completion strobe and read-drive enable.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        accept         = 1'b0;
        drive          = 1'b0;
        mem_data_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_en && mem_req) begin
                    accept  = 1'b1;
                    cnt_n   = lat_load;
                    state_n = (lat_load == 8'd0) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 8'd1;
                if (cnt_n == 8'd0) begin
                    state_n = S_RESPOND;
                end
            end
            S_RESPOND: begin
                mem_data_valid = 1'b1;
                drive          = !wr_q && mem_en;
                state_n        = S_TURN;
            end
            S_TURN: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Byte lanes written: data byte i lands on lane addr[1:0]+i; lanes past 3 are dropped.
    always_comb begin
        wr_be   = '0;
        wr_word = '0;
        for (int b = 0; b < 4; b++) begin
            if ((3'(b) >= {1'b0, addr_q[1:0]}) &&
                ((3'(b) - {1'b0, addr_q[1:0]}) < nbytes)) begin
                wr_be[b]          = 1'b1;
                wr_word[8*b +: 8] = data_q[8*(b - int'(addr_q[1:0])) +: 8];
            end
        end
    end

    // Store commit on the closing edge of a write RESPOND; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (commit && wr_be[b]) begin
                store[addr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

endmodule
